fpu_inq_ctl: RTL



---
 rtl/fpu_inq_ctl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fpu_inq_ctl.sv
// FPU input queue: assembles 1/2-beat PCX requests, precomputes operand flags,
// and buffers them behind a registered head stage with a DEPTH-1 slot FIFO.
module fpu_inq_ctl #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 5,
    parameter int CNT_W = 3
) (
    input  logic            rclk,
    input  logic            rst,
    input  logic            req_vld,
    input  logic [ID_W-1:0] req_id,
    input  logic [7:0]      req_op,
    input  logic [1:0]      req_fcc,
    input  logic [1:0]      req_rnd,
    input  logic [63:0]     req_data,
    output logic            req_busy,
    output logic            inq_vld,
    input  logic            inq_rdy,
    output logic [ID_W-1:0] inq_id,
    output logic [7:0]      inq_op,
    output logic [1:0]      inq_fcc,
    output logic [1:0]      inq_rnd,
    output logic [68:0]     inq_in1,
    output logic [68:0]     inq_in2,
    output logic [CNT_W-1:0] inq_cnt,
    output logic            inq_ovf
);
    localparam int EW = ID_W + 150;
    localparam int FD = DEPTH - 1;
    localparam int PW = (FD > 1) ? $clog2(FD) : 1;
    localparam logic [68:0] IN1_SS = 69'h18_0000_0000_0000_0000;

    typedef enum logic {S_IDLE, S_WAIT2} st_t;

    function automatic logic [68:0] flags(input logic [63:0] d, input logic [7:0] op);
        flags = {!(&d[62:55] && (op[0] || &d[54:52])),
                 !(|d[62:55] || (op[1] && |d[54:52])),
                 |d[53:0], |d[50:0], |d[53:32], d};
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    // Assembler state: beat-0 header and in1 held while waiting for beat 1.
    st_t             r_st;
    logic [ID_W-1:0] r_id;
    logic [7:0]      r_op;
    logic [1:0]      r_fcc;
    logic [1:0]      r_rnd;
    logic [68:0]     r_in1;

    logic            w_cmp;
    logic [EW-1:0]   w_ent;

    always_comb begin
        w_cmp = 1'b0;
        w_ent = {req_id, req_rnd, req_fcc, req_op, IN1_SS, flags(req_data, req_op)};
        if (r_st == S_IDLE) begin
            w_cmp = req_vld && req_op[7];
        end else begin
            w_cmp = req_vld;
            w_ent = {r_id, r_rnd, r_fcc, r_op, r_in1, flags(req_data, r_op)};
        end
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            r_st  <= S_IDLE;
            r_id  <= '0;
            r_op  <= '0;
            r_fcc <= '0;
            r_rnd <= '0;
            r_in1 <= '0;
        end else begin
            case (r_st)
                S_IDLE: if (req_vld && !req_op[7]) begin
                    r_id  <= req_id;
                    r_op  <= req_op;
                    r_fcc <= req_fcc;
                    r_rnd <= req_rnd;
                    r_in1 <= flags(req_data, req_op);
                    r_st  <= S_WAIT2;
                end
                S_WAIT2: if (req_vld) r_st <= S_IDLE;
                default: r_st <= S_IDLE;
            endcase
        end
    end

    // Output side: r_hd is the head register, r_mem the slots behind it.
    logic            r_vld;
    logic [EW-1:0]   r_hd;
    logic [EW-1:0]   r_mem [FD];
    logic [PW-1:0]   r_wp;
    logic [PW-1:0]   r_rp;
    logic [CNT_W-1:0] r_fcnt;
    logic            r_busy;
    logic            r_ovf;

    logic            w_pop;
    logic            w_full;
    logic            w_drop;
    logic            w_acc;
    logic            w_fempty;
    logic            w_fwd;
    logic            w_push;
    logic            w_rd;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_pop     = r_vld && inq_rdy;
    assign w_cnt     = CNT_W'(r_vld) + r_fcnt;
    assign w_full    = (w_cnt == CNT_W'(DEPTH));
    assign w_drop    = w_cmp && w_full && !w_pop;
    assign w_acc     = w_cmp && !w_drop;
    assign w_fempty  = (r_fcnt == '0);
    // Forward straight into the head when nothing is queued behind it.
    assign w_fwd     = w_acc && w_fempty && (!r_vld || w_pop);
    assign w_push    = w_acc && !w_fwd;
    assign w_rd      = w_pop && !w_fempty;
    assign w_cnt_nxt = w_cnt + CNT_W'(w_acc) - CNT_W'(w_pop);

    always_ff @(posedge rclk) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_hd   <= '0;
            r_wp   <= '0;
            r_rp   <= '0;
            r_fcnt <= '0;
            r_busy <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_fwd) begin
                r_vld <= 1'b1;
                r_hd  <= w_ent;
            end else if (w_pop) begin
                r_vld <= !w_fempty;
                if (!w_fempty) r_hd <= r_mem[r_rp];
            end
            if (w_push) r_wp <= ptr_inc(r_wp);
            if (w_rd)   r_rp <= ptr_inc(r_rp);
            r_fcnt <= r_fcnt + CNT_W'(w_push) - CNT_W'(w_rd);
            r_busy <= (w_cnt_nxt >= CNT_W'(DEPTH - 1));
            r_ovf  <= r_ovf || w_drop;
        end
    end

    always_ff @(posedge rclk) begin
        if (w_push) r_mem[r_wp] <= w_ent;
    end

    assign {inq_id, inq_rnd, inq_fcc, inq_op, inq_in1, inq_in2} = r_hd;
    assign inq_vld  = r_vld;
    assign inq_cnt  = w_cnt;
    assign inq_ovf  = r_ovf;
    assign req_busy = r_busy;

endmodule
